clock_div_prog: RTL

Runtime-programmable integer clock divider, the parametrised successor to the fixed divide-by-4/5/6 dividers. It divides `clkIn` by any divisor from 2 to 2^DIV_W−1 and emits a period-start `tick`. Divisor changes are glitch-free because they are applied only at an output-period boundary. It sits in the clock-generation area and feeds derived clocks and strobes to downstream logic.

---
 rtl/clk_div_pkg.sv | 10 +
 rtl/clock_div_prog_if.sv | 22 ++
 rtl/clk_div_duty_fix.sv | 21 ++
 rtl/clock_div_prog.sv | 89 ++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and divisor type for the programmable clock divider
package clk_div_pkg;

    localparam int DIV_W_DEFAULT = 8;
    localparam int MIN_DIV       = 2;
    localparam int DEFAULT_DIV   = 4;

    typedef logic [DIV_W_DEFAULT-1:0] div_t;

endpackage

// File: rtl/clock_div_prog_if.sv
// rtl/clock_div_prog_if.sv - control/status bundle of clock_div_prog (driver = master, divider = slave)
interface clock_div_prog_if #(
    parameter int DIV_W = clk_div_pkg::DIV_W_DEFAULT
);
    logic             enable;
    logic [DIV_W-1:0] div_in;
    logic             load;
    logic             clkDiv;
    logic             tick;
    logic             load_ack;
    logic             load_err;

    modport master (
        output enable, div_in, load,
        input  clkDiv, tick, load_ack, load_err
    );

    modport slave (
        input  enable, div_in, load,
        output clkDiv, tick, load_ack, load_err
    );
endinterface

// File: rtl/clk_div_duty_fix.sv
// rtl/clk_div_duty_fix.sv - negedge stretch of the divided clock for 50% duty at odd divisors
module clk_div_duty_fix (
    input  logic clkIn,
    input  logic reset,
    input  logic clk_pos,
    input  logic odd,
    output logic clk_out
);
    logic clk_neg;

    always_ff @(negedge clkIn or posedge reset) begin
        if (reset) begin
            clk_neg <= 1'b0;
        end else begin
            clk_neg <= clk_pos;
        end
    end

    // Half-cycle extension only for odd divisors; even divisors already have exact duty.
    assign clk_out = clk_pos | (clk_neg & odd);
endmodule

// File: rtl/clock_div_prog.sv
// rtl/clock_div_prog.sv - runtime-programmable integer clock divider; CLKDIV_ODD_DUTY50_EN adds 50% duty at odd divisors
module clock_div_prog #(
    parameter int DIV_W       = clk_div_pkg::DIV_W_DEFAULT,
    parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic                    clkIn,
    input  logic                    reset,
    clock_div_prog_if.slave         bus
);
    import clk_div_pkg::*;

    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;
    logic             pend_v;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nx;
    logic             run;
    logic             clk_q;
    logic             tick_q;
    logic             ack_q;
    logic             err_q;
    logic             load_ok;
    logic             boundary;

    always_comb begin
        cnt_nx = cnt + DIV_W'(1);
        if (!run || cnt == div_act - DIV_W'(1)) begin
            cnt_nx = '0;
        end
    end

    assign load_ok  = bus.load && (bus.div_in >= DIV_W'(MIN_DIV));
    // Disabling counts as a boundary so a pending divisor is never stranded.
    assign boundary = !bus.enable || (cnt_nx == '0);

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            div_act  <= DIV_W'(DEFAULT_DIV);
            div_pend <= '0;
            pend_v   <= 1'b0;
            cnt      <= '0;
            run      <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= bus.load && !load_ok;
            ack_q <= 1'b0;
            if (boundary && pend_v) begin
                div_act <= div_pend;
                pend_v  <= 1'b0;
                ack_q   <= 1'b1;
            end
            // Placed after the apply so a load on a wrap edge stays pending for the next boundary.
            if (load_ok) begin
                div_pend <= bus.div_in;
                pend_v   <= 1'b1;
            end
            if (bus.enable) begin
                cnt    <= cnt_nx;
                run    <= 1'b1;
                clk_q  <= cnt_nx < (div_act >> 1);
                tick_q <= cnt_nx == '0;
            end else begin
                cnt    <= '0;
                run    <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end
        end
    end

`ifdef CLKDIV_ODD_DUTY50_EN
    clk_div_duty_fix u_duty_fix (
        .clkIn   (clkIn),
        .reset   (reset),
        .clk_pos (clk_q),
        .odd     (div_act[0]),
        .clk_out (bus.clkDiv)
    );
`else
    assign bus.clkDiv = clk_q;
`endif

    assign bus.tick     = tick_q;
    assign bus.load_ack = ack_q;
    assign bus.load_err = err_q;
endmodule
